// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath widths and complex sample type
package fft_pkg;

  localparam int FFT_DATA_W    = 19;
  localparam int SDF_MAX_DEPTH = 16;

  typedef struct packed {
    logic [FFT_DATA_W-1:0] re;
    logic [FFT_DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/sdf_cplx_regfile.sv
// rtl/sdf_cplx_regfile.sv - complex-sample register file, combinational read, enabled write, sync clear
module sdf_cplx_regfile #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [2*DATA_W-1:0] i_wdata,
  output logic [2*DATA_W-1:0] o_rdata
);

  logic [2*DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - runtime-length complex delay line for the SDF butterfly feedback path
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int   DATA_W      = FFT_DATA_W,
  parameter int   MAX_DEPTH   = SDF_MAX_DEPTH,
  parameter int   DEFAULT_LEN = SDF_MAX_DEPTH,
  localparam int  LEN_W       = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [LEN_W-1:0]  len_cfg,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_i,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_i,
  output logic              primed,
  output logic [LEN_W-1:0]  active_len
);

  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [AW-1:0]       r_ptr;
  logic [LEN_W-1:0]    r_fill;
  logic [LEN_W-1:0]    r_active_len;
  logic                r_primed;
  logic                w_ptr_last;
  logic                w_we;
  logic [LEN_W-1:0]    w_fill_next;
  logic [2*DATA_W-1:0] w_rdata;

  // Out-of-range requests fall back to the longest delay rather than a degenerate one.
  function automatic logic [LEN_W-1:0] f_clamp(input logic [LEN_W-1:0] v);
    if (v == '0 || v > LEN_W'(MAX_DEPTH)) return LEN_W'(MAX_DEPTH);
    return v;
  endfunction

  assign w_ptr_last  = (LEN_W'(r_ptr) == r_active_len - 1'b1);
  assign w_fill_next = (r_fill == r_active_len) ? r_fill : r_fill + 1'b1;
  assign w_we        = en & ~flush & ~cfg_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_fill       <= '0;
      r_primed     <= 1'b0;
      r_active_len <= LEN_W'(DEFAULT_LEN);
    end else if (flush) begin
      r_ptr    <= '0;
      r_fill   <= '0;
      r_primed <= 1'b0;
    end else if (cfg_load) begin
      r_active_len <= f_clamp(len_cfg);
      r_ptr        <= '0;
      r_fill       <= '0;
      r_primed     <= 1'b0;
    end else if (en) begin
      r_ptr    <= w_ptr_last ? '0 : r_ptr + 1'b1;
      r_fill   <= w_fill_next;
      r_primed <= (w_fill_next == r_active_len);
    end
  end

  sdf_cplx_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DEPTH),
    .AW     (AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_we    (w_we),
    .i_addr  (r_ptr),
    .i_wdata ({in_r, in_i}),
    .o_rdata (w_rdata)
  );

  assign out_r      = w_rdata[2*DATA_W-1:DATA_W];
  assign out_i      = w_rdata[DATA_W-1:0];
  assign primed     = r_primed;
  assign active_len = r_active_len;

endmodule

// File: tb/tb_sdf_delay_line.sv
// tb/tb_sdf_delay_line.sv - scoreboard bench for sdf_delay_line against a counting reference model
module tb_sdf_delay_line;
  import fft_pkg::*;

  localparam int DW = 19;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, cfg_load = 1'b0, flush = 1'b0;
  logic [LW-1:0] len_cfg = '0;
  logic [DW-1:0] in_r = '0, in_i = '0;
  logic [DW-1:0] out_r, out_i;
  logic          primed;
  logic [LW-1:0] active_len;

  sdf_delay_line dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load), .len_cfg(len_cfg),
    .flush(flush), .in_r(in_r), .in_i(in_i), .out_r(out_r), .out_i(out_i),
    .primed(primed), .active_len(active_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          p;
    logic [LW-1:0] len;
  } exp_t;

  exp_t  q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference: k counts enables since the last restart; slot k mod len is both written and read.
  cplx_t m_mem [16];
  int    m_k;
  int    m_len;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 16; j++) m_mem[j] = '0;
    m_k   = 0;
    m_len = 16;
  endtask

  task automatic step(input logic e, input logic c, input logic [LW-1:0] lc,
                      input logic f, input logic [DW-1:0] r, input logic [DW-1:0] im);
    exp_t x;
    @(negedge clk);
    #1;
    en = e; cfg_load = c; len_cfg = lc; flush = f; in_r = r; in_i = im;
    if (f) begin
      for (int j = 0; j < 16; j++) m_mem[j] = '0;
      m_k = 0;
    end else if (c) begin
      m_len = (lc == 0 || lc > 16) ? 16 : int'(lc);
      m_k   = 0;
    end else if (e) begin
      m_mem[m_k % m_len] = '{re: r, im: im};
      m_k++;
    end
    x.r   = m_mem[m_k % m_len].re;
    x.i   = m_mem[m_k % m_len].im;
    x.p   = (m_k >= m_len);
    x.len = LW'(m_len);
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("out_r", 32'(out_r), 32'(x.r));
      chk("out_i", 32'(out_i), 32'(x.i));
      chk("primed", 32'(primed), 32'(x.p));
      chk("active_len", 32'(active_len), 32'(x.len));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset out_r", 32'(out_r), 0);
    chk("reset primed", 32'(primed), 0);
    chk("reset active_len", 32'(active_len), 16);
    #1 rst = 1'b1;

    // Default length 16, strobe held high
    for (int n = 1; n <= 40; n++) step(1'b1, 1'b0, '0, 1'b0, DW'(n), DW'(1000 + n));

    // Length 4, one strobe in three
    step(1'b0, 1'b1, 5'd4, 1'b0, '0, '0);
    for (int n = 1; n <= 12; n++) begin
      step(1'b1, 1'b0, '0, 1'b0, DW'(10 * n), DW'(7 * n));
      idle(2);
    end

    // Reload to 8 mid-stream
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, '0, 1'b0, DW'(500 + n), DW'(n));
    step(1'b0, 1'b1, 5'd8, 1'b0, '0, '0);
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0, '0, 1'b0, DW'(600 + n), DW'(3 * n));

    // Clamp and length-1 cases
    step(1'b0, 1'b1, 5'd0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd20, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd1, 1'b0, '0, '0);
    for (int n = 5; n <= 7; n++) step(1'b1, 1'b0, '0, 1'b0, DW'(n), DW'(n + 1));
    idle(1);

    // flush beats cfg_load beats en
    step(1'b0, 1'b1, 5'd6, 1'b0, '0, '0);
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, '0, 1'b0, DW'(700 + n), DW'(n));
    step(1'b1, 1'b1, 5'd3, 1'b1, DW'(12345), DW'(54321));
    idle(8);

    // Asynchronous reset between edges
    step(1'b0, 1'b1, 5'd16, 1'b0, '0, '0);
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0, '0, 1'b0, DW'(900 + n), DW'(n));
    @(negedge clk);
    #3;
    rst = 1'b0;
    en = 1'b0;
    #1;
    chk("async rst out_r", 32'(out_r), 0);
    chk("async rst out_i", 32'(out_i), 0);
    chk("async rst primed", 32'(primed), 0);
    chk("async rst active_len", 32'(active_len), 16);
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    for (int n = 1; n <= 40; n++) step(1'b1, 1'b0, '0, 1'b0, DW'(n), DW'(2000 + n));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic          e, c, f;
      logic [LW-1:0] lc;
      e  = ($urandom_range(0, 9) < 6);
      c  = ($urandom_range(0, 99) < 5);
      f  = ($urandom_range(0, 99) < 3);
      lc = LW'($urandom_range(0, 20));
      step(e, c, lc, f, DW'($urandom), DW'($urandom));
    end
    idle(2);

    for (int j = 0; j < 5 && q.size() > 0; j++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
